// File: rtl/fetch_sequencer.sv
// Program counter and instruction-fetch controller with a one-entry instruction register.
// Optional FETCH_HALT_ON_ZERO_EN: the all-zero word halts the core instead of being fetched.
module fetch_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted,
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  pc, pc_nx;
    logic [ADDR_W-1:0]  ipc_nx;
    logic [INSTR_W-1:0] iout_nx;
    logic               vld_nx;
    logic               ld, hs, halt_word;

    assign ld        = !instr_valid || instr_ready;
    assign hs        = instr_valid && instr_ready;
    assign imem_addr = pc;
    assign busy      = (state == S_RUN);

`ifdef FETCH_HALT_ON_ZERO_EN
    assign halt_word = (imem_data == '0);
    assign halted    = (state == S_HALT);
`else
    assign halt_word = 1'b0;
    assign halted    = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ipc_nx   = instr_pc;
        iout_nx  = instr_out;
        vld_nx   = instr_valid;
        case (state)
            S_IDLE: begin
                if (hs)
                    vld_nx = 1'b0;
                if (redirect_valid)
                    pc_nx = redirect_pc;
                if (run)
                    state_nx = S_RUN;
            end
            S_RUN: begin
                if (redirect_valid) begin
                    pc_nx  = redirect_pc;
                    vld_nx = 1'b0;
                    if (!run)
                        state_nx = S_IDLE;
                end else if (!run) begin
                    // Stopping still lets the held word drain through its handshake.
                    state_nx = S_IDLE;
                    if (hs)
                        vld_nx = 1'b0;
                end else if (ld && halt_word) begin
                    // pc stays on the halt word so a loader can inspect it.
                    state_nx = S_HALT;
                    vld_nx   = 1'b0;
                end else if (ld) begin
                    iout_nx = imem_data;
                    ipc_nx  = pc;
                    vld_nx  = 1'b1;
                    pc_nx   = pc + ADDR_W'(1);
                end
            end
            S_HALT: begin
                if (!run)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            instr_out   <= iout_nx;
            instr_pc    <= ipc_nx;
            instr_valid <= vld_nx;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer against a queue-based reference model.
module tb_fetch_sequencer;

`ifdef FETCH_HALT_ON_ZERO_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, run, instr_ready, redirect_valid;
    logic [7:0]  redirect_pc, imem_addr, instr_pc;
    logic [15:0] imem_data, instr_out;
    logic        instr_valid, halted, busy;

    always #5 clk = ~clk;

    logic [15:0] mem [0:255];
    logic [15:0] prog [0:9] = '{16'h4800, 16'h4A0C, 16'h4C06, 16'h4E00, 16'h6400,
                                16'h6848, 16'h0E80, 16'h5C02, 16'h8820, 16'h0000};
    assign imem_data = mem[imem_addr];

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .busy(busy)
    );

    int checks = 0, failures = 0, cycle = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Reference: the instruction register is a queue of at most one (pc,word) entry.
    typedef struct packed { logic [7:0] pc; logic [15:0] w; } ent_t;
    ent_t       hold[$];
    ent_t       last;
    int         m_mode;  // 0 idle, 1 running, 2 halted
    logic [7:0] m_pc;

    task automatic model_step();
        bit consumed;
        ent_t e;
        if (!rst_n) begin
            hold.delete(); last = '0; m_mode = 0; m_pc = 8'h00;
            return;
        end
        consumed = (hold.size() != 0) && instr_ready;
        if (m_mode == 0) begin
            if (consumed) void'(hold.pop_front());
            if (redirect_valid) m_pc = redirect_pc;
            if (run) m_mode = 1;
        end else if (m_mode == 1) begin
            if (redirect_valid) begin
                hold.delete();
                m_pc = redirect_pc;
                if (!run) m_mode = 0;
            end else begin
                if (consumed) void'(hold.pop_front());
                if (!run) m_mode = 0;
                else if (hold.size() == 0) begin
                    if (HALT_EN && mem[m_pc] == 16'h0000) m_mode = 2;
                    else begin
                        e.pc = m_pc; e.w = mem[m_pc];
                        hold.push_back(e); last = e;
                        m_pc = m_pc + 8'd1;
                    end
                end
            end
        end else if (!run) m_mode = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cycle++;
        chk("addr",   imem_addr,   m_pc);
        chk("valid",  instr_valid, hold.size() != 0);
        chk("iout",   instr_out,   last.w);
        chk("ipc",    instr_pc,    last.pc);
        chk("busy",   busy,        m_mode == 1);
        chk("halted", halted,      m_mode == 2);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"},   imem_addr,   8'h00);
        chk({tag, "_valid"},  instr_valid, 1'b0);
        chk({tag, "_iout"},   instr_out,   16'h0000);
        chk({tag, "_ipc"},    instr_pc,    8'h00);
        chk({tag, "_busy"},   busy,        1'b0);
        chk({tag, "_halted"}, halted,      1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; redirect_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    // Run until the word fetched from address a is presented, within a cycle budget.
    task automatic wait_word(input logic [7:0] a, input string tag);
        int b;
        for (b = 0; b < 30; b++) begin
            cyc();
            if (instr_valid && instr_pc == a) break;
        end
        chk({tag, "_reached"}, b < 30, 1'b1);
    endtask

    logic [7:0]  gp [0:9];
    logic [15:0] gw [0:9];
    int          gc [0:9];
    int          n;

    initial begin
        rst_n = 1'b0; run = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(1, 16'hFFFF));
        for (int i = 0; i < 10; i++) mem[i] = prog[i];

        cyc();
        chk_reset_vals("rst");

        // Straight-line program with the consumer always ready.
        rst_n = 1'b1; instr_ready = 1'b1; run = 1'b1; n = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (instr_valid) begin
                if (n < 10) begin gp[n] = instr_pc; gw[n] = instr_out; gc[n] = cycle; end
                n++;
            end
        end
        chk("prog_count", n, HALT_EN ? 9 : 11);
        for (int i = 0; i < 9; i++) begin
            chk("prog_pc", gp[i], 8'(i));
            chk("prog_word", gw[i], prog[i]);
            chk("prog_back2back", gc[i], gc[0] + i);
        end
        if (!HALT_EN) begin
            chk("nop_pc", gp[9], 8'h09);
            chk("nop_word", gw[9], 16'h0000);
        end
        chk("end_halted", halted, HALT_EN);
        chk("end_pc", imem_addr, HALT_EN ? 8'h09 : 8'h0B);
        run = 1'b0;
        cyc();
        chk("unhalt", halted, 1'b0);

        // Back-pressure on word 02.
        do_reset(); run = 1'b1; instr_ready = 1'b1;
        wait_word(8'h02, "stall");
        instr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("stall_word", instr_out, 16'h4C06);
            chk("stall_pc", imem_addr, 8'h03);
            if (k < 3) cyc();
        end
        instr_ready = 1'b1;
        cyc();
        chk("stall_next_pc", instr_pc, 8'h03);
        chk("stall_next_word", instr_out, 16'h4E00);

        // Redirect while word 01 is held.
        do_reset(); run = 1'b1; instr_ready = 1'b1;
        wait_word(8'h01, "redir");
        instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h07;
        cyc();
        chk("redir_flush", instr_valid, 1'b0);
        redirect_valid = 1'b0; instr_ready = 1'b1;
        cyc();
        chk("redir_w1", {instr_valid, instr_pc, instr_out}, {1'b1, 8'h07, 16'h5C02});
        cyc();
        chk("redir_w2", {instr_valid, instr_pc, instr_out}, {1'b1, 8'h08, 16'h8820});

        // Start address set from IDLE, pc wrap.
        mem[8'hFE] = 16'h1111; mem[8'hFF] = 16'h2222;
        do_reset(); redirect_valid = 1'b1; redirect_pc = 8'hFE;
        cyc();
        chk("wrap_start", imem_addr, 8'hFE);
        redirect_valid = 1'b0; run = 1'b1; instr_ready = 1'b1;
        cyc();
        cyc();
        chk("wrap_w1", {instr_valid, instr_pc, instr_out}, {1'b1, 8'hFE, 16'h1111});
        cyc();
        chk("wrap_w2", {instr_valid, instr_pc, instr_out}, {1'b1, 8'hFF, 16'h2222});
        chk("wrap_addr", imem_addr, 8'h00);
        cyc();
        chk("wrap_w3", {instr_valid, instr_pc, instr_out}, {1'b1, 8'h00, 16'h4800});

        // Reset while a word is held, then restart.
        wait_word(8'h03, "mid");
        rst_n = 1'b0;
        cyc();
        chk_reset_vals("midrst");
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("restart", {instr_valid, instr_pc, instr_out}, {1'b1, 8'h00, 16'h4800});

        // Randomized traffic; the model checks every cycle.
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst_n          = ($urandom_range(0, 199) != 0);
            run            = ($urandom_range(0, 15) != 0);
            instr_ready    = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 8'($urandom);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and instruction-fetch controller for the 8-bit core. It drives the address of the combinational 16-bit instruction memory and captures each fetched word into a one-entry instruction register. The decode/execute stage consumes words through a valid/ready handshake, and the sequencer accepts PC redirects from branches, jumps or a program loader. It also halts the core on the all-zero instruction word when that feature is compiled in.

## Interface
- `ADDR_W`, 8, program counter and instruction-memory address width.
- `INSTR_W`, 16, instruction word width.
- `RESET_PC`, 8'h00, program counter value after reset.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `run`  in  1  level; 1 = fetch, 0 = stop after the current word drains.
- `imem_addr`  out  ADDR_W  instruction-memory address; combinationally equal to `pc`.
- `imem_data`  in  INSTR_W  combinational read data for `imem_addr`.
- `instr_out`  out  INSTR_W  registered instruction word.
- `instr_pc`  out  ADDR_W  address the word in `instr_out` was fetched from.
- `instr_valid`  out  1  `instr_out` holds an unconsumed word.
- `instr_ready`  in  1  consumer accepts `instr_out` this cycle.
- `redirect_valid`  in  1  load `redirect_pc` into `pc`.
- `redirect_pc`  in  ADDR_W  new fetch address.
- `halted`  out  1  the sequencer is in HALT.
- `busy`  out  1  the sequencer is in RUN.

## Operation
- The FSM has three states: IDLE, RUN and HALT. Reset enters IDLE.
- The load condition is `ld = !instr_valid || instr_ready`.
- A handshake completes on any cycle where `instr_valid && instr_ready`.
- **IDLE**
  - No fetches.
  - A completed handshake clears `instr_valid`.
  - `redirect_valid` sets `pc <= redirect_pc`. This is how the start address is set.
  - `run=1` moves to RUN on the next edge.
- **RUN**, applied in priority order:
  1. `redirect_valid`: `pc <= redirect_pc`. `instr_valid <= 0`, which flushes the held word whether or not it was consumed. No capture this cycle. If `run=0` in the same cycle, the next state is IDLE.
  2. `run=0`: next state is IDLE. No capture. A valid word stays valid until its handshake completes.
  3. `ld` with the halt word (macro only): next state is HALT. `instr_valid <= 0`. `pc` is unchanged and keeps pointing at the halt word.
  4. `ld` otherwise: `instr_out <= imem_data`, `instr_pc <= pc`, `instr_valid <= 1`, `pc <= pc + 1`.
  5. No `ld`: all registers hold.
- **HALT**
  - `halted=1`; no fetches.
  - `redirect_valid` is ignored.
  - `run=0` moves to IDLE and clears `halted`.
- `pc` arithmetic is modulo 2^ADDR_W, so 8'hFF + 1 wraps to 8'h00 with no flag.
- `busy = (state == RUN)`.

## Timing
- Reset values: `pc=RESET_PC`, `imem_addr=RESET_PC`, `instr_out=0`, `instr_pc=0`, `instr_valid=0`, `halted=0`, `busy=0`.
- Reset mid-operation discards the held word and any pending redirect.
- Start latency: `run` sampled high at edge N gives RUN after edge N. The first capture happens at edge N+1, so `instr_valid` goes high after edge N+1.
- Throughput is one word per cycle while `instr_ready=1`.
- `instr_out` and `instr_pc` are stable while `instr_valid && !instr_ready`.
- A redirect in cycle N takes effect after edge N:
  - `instr_valid=0` during cycle N+1.
  - The first word from `redirect_pc` is valid after edge N+1.
- `halted` rises at the edge that detects the halt word. The last real word is consumed on or before that edge.
- `imem_addr` changes only at clock edges.

## Configuration
- `FETCH_HALT_ON_ZERO_EN`
  - **Defined:** an `imem_data` of 16'h0000 at a RUN `ld` cycle triggers the HALT transition. The word is never presented on `instr_out`.
  - **Undefined:** 16'h0000 is passed through as an ordinary NOP word. HALT is unreachable, and `halted` is tied to 0.

## Test plan
- Memory holds 4800,4A0C,4C06,4E00,6400,6848,0E80,5C02,8820,0000 at 00–09, macro defined, `instr_ready=1`, `run` raised -> the bench sees `instr_valid` for (pc,word) pairs 00/4800 through 08/8820 in consecutive cycles. After edge 11, `halted=1`, `pc=09`, `instr_valid=0`.
- Same program, `instr_ready=0` for 3 cycles after word 02/4C06 appears -> 4C06 is held unchanged for 4 cycles and `pc` stays at 03. Then 4E00 follows 4C06 immediately after the handshake.
- In RUN, with 01/4A0C valid and unconsumed, assert `redirect_valid` with `redirect_pc=07` -> 4A0C is dropped and `instr_valid=0` for one cycle. Then 07/5C02 and 08/8820 follow.
- In IDLE, redirect to FE, raise `run`, memory word at FE/FF/00 is 1111/2222/4800 -> the bench sees FE/1111, FF/2222, 00/4800. The pc wraps with no glitch.
- Hold `rst_n=0` for one edge while `instr_valid=1` in mid-program -> all outputs read their reset values and the state is IDLE. Then `run` restarts fetch from 00.
- Macro undefined with the same program -> 09/0000 is presented as a word and `halted` stays 0. Fetch continues at 0A.
